// File: rtl/hs_east_tx_packer_if.sv
// Sample stream into the east high-speed bus packer: complex I/Q samples with valid/ready.
interface hs_east_tx_packer_if #(
  parameter int DATA_BITS = 18
);
  logic [DATA_BITS-1:0] i_data_re;
  logic [DATA_BITS-1:0] i_data_im;
  logic                 i_valid;
  logic                 o_ready;

  modport master (output i_data_re, output i_data_im, output i_valid, input o_ready);
  modport slave  (input i_data_re, input i_data_im, input i_valid, output o_ready);
endinterface

// File: rtl/hs_east_tx_packer.sv
// Buffers I/Q samples in a small FIFO and drives the registered {valid, im, re, parity} word
// onto the east high-speed bus, with one-shot parity corruption and a transmitted-word counter.
module hs_east_tx_packer #(
  parameter int DATA_BITS  = 18,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_BITS   = 32
) (
  input  logic                            i_sysclk,
  input  logic                            i_rst_n,
  hs_east_tx_packer_if.slave              s_if,
  input  logic                            i_tx_en,
  input  logic                            i_inject_perr,
  input  logic                            i_clear_cnt,
  output logic [2*DATA_BITS+1:0]          o_hs_bus,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_level,
  output logic                            o_perr_pending,
  output logic [CNT_BITS-1:0]             o_word_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BUS_W = 2*DATA_BITS + 2;

  logic [2*DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic [BUS_W-1:0]       bus_q, bus_d;
  logic                   pend_q, pend_d;
  logic [CNT_BITS-1:0]    cnt_q, cnt_d;

  logic                   push, pop, corrupt;
  logic [2*DATA_BITS-1:0] head;

  function automatic logic even_par(input logic [DATA_BITS-1:0] re,
                                    input logic [DATA_BITS-1:0] im);
    return (^re) ^ (^im);
  endfunction

  // Ready comes from the registered level only, held low while reset is asserted.
  assign s_if.o_ready = i_rst_n && (level_q < LVL_W'(FIFO_DEPTH));

  assign push = s_if.i_valid & s_if.o_ready;
  assign pop  = i_tx_en && (level_q != '0);
  assign head = mem_q[rd_ptr_q];
  // A request arriving on the same edge as a pop is consumed immediately.
  assign corrupt = pop & (pend_q | i_inject_perr);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    bus_d    = '0;
    pend_d   = pend_q | i_inject_perr;
    cnt_d    = cnt_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      bus_d    = {1'b1, head,
                  even_par(head[DATA_BITS-1:0], head[2*DATA_BITS-1:DATA_BITS]) ^ corrupt};
      cnt_d    = cnt_q + 1'b1;
    end

    if (corrupt) pend_d = 1'b0;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (i_clear_cnt) cnt_d = '0;
  end

  always_ff @(posedge i_sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      bus_q    <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      bus_q    <= bus_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
    end
  end

  // Sample storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge i_sysclk) begin
    if (push) mem_q[wr_ptr_q] <= {s_if.i_data_im, s_if.i_data_re};
  end

  assign o_hs_bus       = bus_q;
  assign o_fifo_level   = level_q;
  assign o_perr_pending = pend_q;
  assign o_word_cnt     = cnt_q;
endmodule
